// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative unsigned shift-add multiplier execution unit.
// It accepts operands from the control block, computes a 2*WIDTH-bit
// product one bit per cycle, and writes it back into the register array
// in two cycles: the high word goes to dst, the low word to dst+1 (mod 8).
// All outputs are registered, so there is no combinational path from
// start to any output.
module seq_mult_unit #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [2:0]           dst_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 reg_wr,
    output logic [2:0]           reg_wr_sel,
    output logic [WIDTH-1:0]     reg_wr_data,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WB_HI = 2'd2,
        S_WB_LO = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           dst_q, dst_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 reg_wr_q, reg_wr_d;
    logic [2:0]           reg_wr_sel_q, reg_wr_sel_d;
    logic [WIDTH-1:0]     reg_wr_data_q, reg_wr_data_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Result of the current RUN iteration; also feeds the high-word write
    // so the WB_HI cycle already presents the final accumulator.
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shr;
    logic                 last_iter;

    // Next-state and registered-output logic for the multiply sequence.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it
        // unassigned; a missing default would infer a latch.
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        cnt_d         = cnt_q;
        dst_d         = dst_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        reg_wr_d      = 1'b0;
        reg_wr_sel_d  = reg_wr_sel_q;
        reg_wr_data_d = reg_wr_data_q;
        product_d     = product_q;

        acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shr = mplier_q >> 1;
        last_iter  = (cnt_q == CNT_W'(WIDTH - 1)) ||
                     ((EARLY_EXIT != 0) && (mplier_shr == '0));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, op_a};
                    mplier_d = op_b;
                    dst_d    = dst_sel;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    reg_wr_d      = 1'b1;
                    reg_wr_sel_d  = dst_q;
                    reg_wr_data_d = acc_sum[2*WIDTH-1:WIDTH];
                    state_d       = S_WB_HI;
                end
            end

            S_WB_HI: begin
                // Low-word write; the 3-bit add wraps R7 onto R0.
                reg_wr_d      = 1'b1;
                reg_wr_sel_d  = dst_q + 3'd1;
                reg_wr_data_d = acc_q[WIDTH-1:0];
                done_d        = 1'b1;
                product_d     = acc_q;
                state_d       = S_WB_LO;
            end

            S_WB_LO: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            cnt_q         <= '0;
            dst_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_wr_sel_q  <= '0;
            reg_wr_data_q <= '0;
            product_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q       <= state_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            cnt_q         <= cnt_d;
            dst_q         <= dst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            reg_wr_q      <= reg_wr_d;
            reg_wr_sel_q  <= reg_wr_sel_d;
            reg_wr_data_q <= reg_wr_data_d;
            product_q     <= product_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign reg_wr      = reg_wr_q;
    assign reg_wr_sel  = reg_wr_sel_q;
    assign reg_wr_data = reg_wr_data_q;
    assign product     = product_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: a fixed-latency instance checked through a
// scoreboard queue, plus an early-exit instance checked inline.
module tb_seq_mult_unit;

    localparam int W = 16;

    logic            clock = 1'b0;
    logic            reset;

    logic            start;
    logic [W-1:0]    op_a, op_b;
    logic [2:0]      dst_sel;
    logic            busy, done, reg_wr;
    logic [2:0]      reg_wr_sel;
    logic [W-1:0]    reg_wr_data;
    logic [2*W-1:0]  product;

    logic            e_start;
    logic [W-1:0]    e_op_a, e_op_b;
    logic [2:0]      e_dst_sel;
    logic            e_busy, e_done, e_reg_wr;
    logic [2:0]      e_reg_wr_sel;
    logic [W-1:0]    e_reg_wr_data;
    logic [2*W-1:0]  e_product;

    always #5 clock = ~clock;

    seq_mult_unit #(.WIDTH(W), .EARLY_EXIT(0)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .op_a(op_a), .op_b(op_b), .dst_sel(dst_sel),
        .busy(busy), .done(done), .reg_wr(reg_wr),
        .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data), .product(product)
    );

    seq_mult_unit #(.WIDTH(W), .EARLY_EXIT(1)) u_dut_ee (
        .clock(clock), .reset(reset), .start(e_start),
        .op_a(e_op_a), .op_b(e_op_b), .dst_sel(e_dst_sel),
        .busy(e_busy), .done(e_done), .reg_wr(e_reg_wr),
        .reg_wr_sel(e_reg_wr_sel), .reg_wr_data(e_reg_wr_data), .product(e_product)
    );

    typedef struct {
        logic [2:0]     dst;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t           sb_q[$];
    int             checks = 0;
    int             errors = 0;
    int             wr_phase = 0;
    logic           prod_pending = 1'b0;
    logic [2*W-1:0] prod_exp;

    // Scoreboard monitor: each done must follow exactly two writes
    // (dst/high word, then dst+1/low word), and product must then hold.
    always @(negedge clock) begin
        if (reset) begin
            wr_phase     = 0;
            prod_pending = 1'b0;
        end else begin
            if (prod_pending) begin
                checks++;
                if (product !== prod_exp) begin
                    errors++;
                    $display("FAIL product_hold got=%h want=%h", product, prod_exp);
                end
                prod_pending = 1'b0;
            end
            if (reg_wr) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr sel=%0d data=%h", reg_wr_sel, reg_wr_data);
                end else if (wr_phase == 0) begin
                    if (reg_wr_sel !== sb_q[0].dst || reg_wr_data !== sb_q[0].prod[2*W-1:W]) begin
                        errors++;
                        $display("FAIL wr_hi got sel=%0d data=%h want sel=%0d data=%h",
                                 reg_wr_sel, reg_wr_data, sb_q[0].dst, sb_q[0].prod[2*W-1:W]);
                    end
                end else if (wr_phase == 1) begin
                    if (reg_wr_sel !== 3'(sb_q[0].dst + 3'd1) || reg_wr_data !== sb_q[0].prod[W-1:0]) begin
                        errors++;
                        $display("FAIL wr_lo got sel=%0d data=%h want sel=%0d data=%h",
                                 reg_wr_sel, reg_wr_data, 3'(sb_q[0].dst + 3'd1), sb_q[0].prod[W-1:0]);
                    end
                end else begin
                    errors++;
                    $display("FAIL extra_wr got phase=%0d want phase<2", wr_phase);
                end
                wr_phase++;
            end
            if (done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got done=1 want no pending op");
                end else begin
                    if (wr_phase != 2) begin
                        errors++;
                        $display("FAIL done_writes got %0d writes want 2", wr_phase);
                    end
                    prod_exp     = sb_q[0].prod;
                    prod_pending = 1'b1;
                    void'(sb_q.pop_front());
                end
                wr_phase = 0;
            end
        end
    end

    // Issue one op on the fixed-latency unit in the next cycle and return
    // the cycle index (N+lat) in which done is seen; -1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] d, output int lat);
        exp_t e;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_issue got busy=%b want 0", busy);
        end
        start   = 1'b1;
        op_a    = a;
        op_b    = b;
        dst_sel = d;
        e.dst   = d;
        e.prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sb_q.push_back(e);
        lat = -1;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(negedge clock);
            if (i == 1) begin
                // Scramble the inputs: only the accepted values may matter.
                start   = 1'b0;
                op_a    = W'($urandom);
                op_b    = W'($urandom);
                dst_sel = 3'($urandom);
            end
            if (done) lat = i;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got none want done within 60 cycles");
        end
    endtask

    // Reset state on both instances, then release.
    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({busy, done, reg_wr, reg_wr_sel, reg_wr_data, product} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b wr=%b sel=%0d data=%h prod=%h want all 0",
                     busy, done, reg_wr, reg_wr_sel, reg_wr_data, product);
        end
        checks++;
        if ({e_busy, e_done, e_reg_wr, e_reg_wr_sel, e_reg_wr_data, e_product} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_ee got busy=%b done=%b wr=%b want all 0",
                     e_busy, e_done, e_reg_wr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b wr=%b want 0 0", busy, reg_wr);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_op(16'h0003, 16'h0005, 3'd2, lat);
        checks++;
        if (lat != W + 2) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d", lat, W + 2);
        end
        @(negedge clock);
        checks++;
        if (product !== 32'h0000_000F) begin
            errors++;
            $display("FAIL basic_product got %h want 0000000f", product);
        end
    endtask

    task automatic test_full_range();
        int lat;
        run_op(16'hFFFF, 16'hFFFF, 3'd4, lat);
        @(negedge clock);
        checks++;
        if (product !== 32'hFFFE_0001) begin
            errors++;
            $display("FAIL full_range_product got %h want fffe0001", product);
        end
    endtask

    task automatic test_wrap();
        int lat;
        run_op(16'h1234, 16'h0100, 3'd7, lat);
        @(negedge clock);
        checks++;
        if (product !== 32'h0012_3400) begin
            errors++;
            $display("FAIL wrap_product got %h want 00123400", product);
        end
    endtask

    // A start while busy is ignored; a start in the first IDLE cycle after
    // done is accepted.
    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        @(negedge clock);
        start   = 1'b1;
        op_a    = 16'h00AA;
        op_b    = 16'h0011;
        dst_sel = 3'd1;
        e.dst   = 3'd1;
        e.prod  = 32'h0000_0B4A;
        sb_q.push_back(e);
        lat = -1;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(negedge clock);
            if (i == 1) start = 1'b0;
            if (i == 5) begin
                start   = 1'b1;
                op_a    = 16'hFFFF;
                op_b    = 16'hFFFF;
                dst_sel = 3'd6;
            end
            if (i == 6) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during_run got %b want 1", busy);
                end
            end
            if (done) lat = i;
        end
        checks++;
        if (lat != W + 2) begin
            errors++;
            $display("FAIL ignore_latency got %0d want %0d", lat, W + 2);
        end
        run_op(16'h0101, 16'h0202, 3'd3, lat);
        checks++;
        if (lat != W + 2) begin
            errors++;
            $display("FAIL back_to_back_latency got %0d want %0d", lat, W + 2);
        end
    endtask

    // Asynchronous reset in the middle of RUN clears everything at once
    // and suppresses the write-back.
    task automatic test_async_reset();
        int lat;
        exp_t e;
        @(negedge clock);
        start   = 1'b1;
        op_a    = 16'h0005;
        op_b    = 16'h0007;
        dst_sel = 3'd1;
        e.dst   = 3'd1;
        e.prod  = 32'h0000_0023;
        sb_q.push_back(e);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 1) start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, reg_wr, reg_wr_sel, reg_wr_data, product} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got busy=%b done=%b wr=%b sel=%0d data=%h prod=%h want all 0",
                     busy, done, reg_wr, reg_wr_sel, reg_wr_data, product);
        end
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (reg_wr !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL wr_during_reset got wr=%b done=%b want 0 0", reg_wr, done);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if (reg_wr !== 1'b0) begin
                errors++;
                $display("FAIL wr_after_abort got %b want 0", reg_wr);
            end
        end
        run_op(16'h0002, 16'h0003, 3'd0, lat);
        @(negedge clock);
        checks++;
        if (product !== 32'h0000_0006) begin
            errors++;
            $display("FAIL post_reset_product got %h want 00000006", product);
        end
    endtask

    // One op on the early-exit instance: RUN lasts as many cycles as op_b
    // has significant bits (at least one), then two write-back cycles.
    task automatic ee_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] d);
        logic [2*W-1:0] p;
        int nb;
        int lat;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        nb = 1;
        for (int k = 0; k < W; k++) if (b[k]) nb = k + 1;
        @(negedge clock);
        e_start   = 1'b1;
        e_op_a    = a;
        e_op_b    = b;
        e_dst_sel = d;
        lat = -1;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(negedge clock);
            if (i == 1) e_start = 1'b0;
            if (e_reg_wr && !e_done) begin
                checks++;
                if (e_reg_wr_sel !== d || e_reg_wr_data !== p[2*W-1:W] || i != nb + 1) begin
                    errors++;
                    $display("FAIL ee_wr_hi got sel=%0d data=%h cyc=%0d want sel=%0d data=%h cyc=%0d",
                             e_reg_wr_sel, e_reg_wr_data, i, d, p[2*W-1:W], nb + 1);
                end
            end
            if (e_done) begin
                lat = i;
                checks++;
                if (e_reg_wr !== 1'b1 || e_reg_wr_sel !== 3'(d + 3'd1) || e_reg_wr_data !== p[W-1:0]) begin
                    errors++;
                    $display("FAIL ee_wr_lo got wr=%b sel=%0d data=%h want 1 %0d %h",
                             e_reg_wr, e_reg_wr_sel, e_reg_wr_data, 3'(d + 3'd1), p[W-1:0]);
                end
            end
        end
        checks++;
        if (lat != nb + 2) begin
            errors++;
            $display("FAIL ee_latency a=%h b=%h got %0d want %0d", a, b, lat, nb + 2);
        end
        @(negedge clock);
        checks++;
        if (e_product !== p || e_busy !== 1'b0) begin
            errors++;
            $display("FAIL ee_product got %h busy=%b want %h busy=0", e_product, e_busy, p);
        end
    endtask

    task automatic test_early_exit();
        ee_op(16'h1234, 16'h0001, 3'd5);
        ee_op(16'hBEEF, 16'h0000, 3'd0);
        ee_op(16'h0003, 16'h0006, 3'd2);
        ee_op(16'h00FF, 16'h8000, 3'd7);
        for (int n = 0; n < 30; n++)
            ee_op(W'($urandom), W'($urandom_range(0, 255)), 3'($urandom));
    endtask

    task automatic test_random();
        int lat;
        int bad_lat;
        bad_lat = 0;
        for (int n = 0; n < 1000; n++) begin
            run_op(W'($urandom), W'($urandom), 3'($urandom), lat);
            checks++;
            if (lat != W + 2) begin
                errors++;
                if (bad_lat < 5)
                    $display("FAIL random_latency got %0d want %0d", lat, W + 2);
                bad_lat++;
            end
        end
        repeat (2) @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        dst_sel   = '0;
        e_start   = 1'b0;
        e_op_a    = '0;
        e_op_b    = '0;
        e_dst_sel = '0;
        repeat (2) @(negedge clock);
        test_reset();
        test_basic();
        test_full_range();
        test_wrap();
        test_busy_ignore();
        test_async_reset();
        test_early_exit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Iterative unsigned shift-add multiplier execution unit that sits directly downstream of the control block.
- The control block issues the MUX R3 R1 R2 operands and destination. This unit computes the 2*WIDTH-bit product and writes it back into the register array: high word to R3, low word to R3+1.
- It replaces the controller's hand-sequenced mux3..mux9 loop with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH.
- EARLY_EXIT, 0, when 1 the unit leaves RUN as soon as the remaining multiplier is zero; when 0 latency is fixed.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- op_a  input  WIDTH  multiplicand (R1 contents)
- op_b  input  WIDTH  multiplier (R2 contents)
- dst_sel  input  3  destination register index (R3)
- busy  output  1  high from the cycle after an accepted start through the WB_LO cycle
- done  output  1  one-cycle pulse in the WB_LO cycle
- reg_wr  output  1  register array write enable
- reg_wr_sel  output  3  register array write address
- reg_wr_data  output  WIDTH  register array write data
- product  output  2*WIDTH  last completed product, held until the next completion

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; reg_wr=0; reg_wr_sel=0; reg_wr_data=0; product=0; internal acc, mcand, mplier and cnt all cleared.
- Reset mid-operation aborts the multiply; no write-back occurs.
- All outputs are registered (Moore); nothing combinational from start to the outputs.
- States: IDLE, RUN, WB_HI, WB_LO.
- IDLE:
  - If start=1, latch mcand={WIDTH zeros, op_a}, mplier=op_b, dst=dst_sel; set acc=0, cnt=0; go to RUN.
  - Otherwise remain in IDLE.
- RUN, one iteration per cycle:
  - If mplier[0]=1, acc = acc + mcand, computed in 2*WIDTH bits; no overflow is possible.
  - Then mcand <<= 1, mplier >>= 1, cnt += 1.
  - Leave to WB_HI after the iteration where cnt reaches WIDTH-1, i.e. exactly WIDTH RUN cycles.
  - If EARLY_EXIT=1, also leave to WB_HI when the shifted mplier becomes 0. An op_b=0 start still spends 1 RUN cycle.
- WB_HI: reg_wr=1, reg_wr_sel=dst, reg_wr_data=acc[2*WIDTH-1:WIDTH]; go to WB_LO.
- WB_LO:
  - reg_wr=1, reg_wr_sel=dst+1 (3-bit, so 7 wraps to 0), reg_wr_data=acc[WIDTH-1:0].
  - done=1; product<=acc; go to IDLE.
- Latency with EARLY_EXIT=0: start sampled at edge N; RUN occupies cycles N+1..N+WIDTH; WB_HI at N+WIDTH+1; WB_LO/done at N+WIDTH+2. For WIDTH=16, done is 18 cycles after the start edge.
- Back-to-back: start sampled in the first IDLE cycle after WB_LO is accepted, giving a minimum issue interval of WIDTH+3 cycles.
- start while busy=1 is ignored (not queued). The operands and dst_sel are sampled only at acceptance, so later changes have no effect.
- reg_wr_sel and reg_wr_data hold their last values when reg_wr=0. Consumers must qualify them with reg_wr.
- The write addresses are the same for dst=R1/R2 aliasing; the operands are already latched, so the result is correct.

Test Plan:
- Basic: op_a=0x0003, op_b=0x0005, dst=2 -> WB_HI writes R2=0x0000 at N+17, WB_LO writes R3=0x000F at N+18, done=1 for one cycle, product=0x0000000F.
- Full range: op_a=0xFFFF, op_b=0xFFFF, dst=4 -> R4=0xFFFE, R5=0x0001, product=0xFFFE0001.
- Wrap: op_a=0x1234, op_b=0x0100, dst=7 -> R7=0x0012, then R0=0x3400. With EARLY_EXIT=1, op_b=0x0001 -> done at N+3 (1 RUN cycle).
- Busy/ignore: start pulsed again at N+5 with different operands -> no effect, busy stays 1, first result unchanged. A start at the first IDLE cycle after done -> accepted, second result correct.
- Async reset at N+8 mid-RUN -> all outputs 0 immediately, no reg_wr pulse. A following start with op_a=2, op_b=3 -> product=0x00000006.
- Random: 1000 random op_a/op_b/dst pairs checked against a reference model; every done is preceded by exactly two reg_wr cycles (dst, then dst+1 mod 8).
